fsm_bit_packer: RTL and testbench

Downstream stage for the serial Mealy FSM output stream. Consumes the per-cycle output bit `y` (qualified by a valid strobe), packs bits MSB-first into WIDTH-bit words, and presents each word on a valid/ready handshake. Optionally runs an overlapping "1011" detector on the same stream and counts matches.

---
 rtl/fsm_pkg.sv | 15 +
 rtl/seq_det_1011.sv | 63 ++++++
 rtl/fsm_bit_packer.sv | 102 ++++++++++
 tb/tb_fsm_bit_packer.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/fsm_pkg.sv
// Shared types and constants for the bit packer and its "1011" pattern detector.
package fsm_pkg;

  typedef enum logic [1:0] {
    S0,
    S1,
    S10,
    S101
  } det_state_e;

  localparam logic [3:0] PATTERN   = 4'b1011;
  localparam int         DEF_WIDTH = 8;
  localparam int         DEF_CNT_W = 8;

endpackage

// File: rtl/seq_det_1011.sv
// Overlapping "1011" Mealy detector with a registered match pulse and a
// saturating match counter; it advances only on qualified bits.
module seq_det_1011
  import fsm_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             bit_i,
  input  logic             vld_i,
  output logic             det_o,
  output logic [CNT_W-1:0] det_cnt_o
);

  det_state_e       state_q, state_d;
  logic             det_q, det_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S0;
      det_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      det_q   <= det_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    det_d   = 1'b0;
    cnt_d   = cnt_q;
    if (clr_i) begin
      state_d = S0;
      cnt_d   = '0;
    end else if (vld_i) begin
      unique case (state_q)
        S0:   state_d = bit_i ? S1 : S0;
        S1:   state_d = bit_i ? S1 : S10;
        S10:  state_d = bit_i ? S101 : S0;
        S101: begin
          // The trailing '1' of a match is also the leading '1' of the next.
          if (bit_i == PATTERN[0]) begin
            state_d = S1;
            det_d   = 1'b1;
            if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
          end else begin
            state_d = S10;
          end
        end
        default: state_d = S0;
      endcase
    end
  end

  assign det_o     = det_q;
  assign det_cnt_o = cnt_q;

endmodule

// File: rtl/fsm_bit_packer.sv
// Packs a qualified serial bit stream MSB-first into WIDTH-bit words behind a
// valid/ready handshake. Define PATTERN_DET_EN to add the "1011" detector.
module fsm_bit_packer
  import fsm_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             bit_vld,
  input  logic             frame_clr,
  output logic [WIDTH-1:0] data_out,
  output logic             data_vld,
  input  logic             data_rdy,
  output logic             overflow,
  output logic             det,
  output logic [CNT_W-1:0] det_cnt
);

  localparam int              BC_W = $clog2(WIDTH);
  localparam logic [BC_W-1:0] LAST = BC_W'(WIDTH - 1);

  logic [BC_W-1:0]  bcnt_q, bcnt_d;
  logic [WIDTH-2:0] shift_q, shift_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             vld_q, vld_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] word;
  logic             word_done;

  assign word      = {shift_q, bit_in};
  assign word_done = bit_vld && (bcnt_q == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bcnt_q  <= '0;
      shift_q <= '0;
      dout_q  <= '0;
      vld_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      bcnt_q  <= bcnt_d;
      shift_q <= shift_d;
      dout_q  <= dout_d;
      vld_q   <= vld_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    bcnt_d  = bcnt_q;
    shift_d = shift_q;
    dout_d  = dout_q;
    vld_d   = vld_q;
    ovf_d   = ovf_q;
    if (frame_clr) begin
      // data_out is deliberately kept so the last word stays observable.
      bcnt_d  = '0;
      shift_d = '0;
      vld_d   = 1'b0;
      ovf_d   = 1'b0;
    end else begin
      if (bit_vld) begin
        shift_d = word[WIDTH-2:0];
        bcnt_d  = word_done ? '0 : bcnt_q + BC_W'(1);
      end
      if (vld_q && data_rdy) vld_d = 1'b0;
      if (word_done) begin
        if (!vld_q || data_rdy) begin
          dout_d = word;
          vld_d  = 1'b1;
        end else begin
          ovf_d  = 1'b1;
        end
      end
    end
  end

  assign data_out = dout_q;
  assign data_vld = vld_q;
  assign overflow = ovf_q;

`ifdef PATTERN_DET_EN
  seq_det_1011 #(
    .CNT_W (CNT_W)
  ) u_det (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (frame_clr),
    .bit_i     (bit_in),
    .vld_i     (bit_vld),
    .det_o     (det),
    .det_cnt_o (det_cnt)
  );
`else
  assign det     = 1'b0;
  assign det_cnt = '0;
`endif

endmodule

// File: tb/tb_fsm_bit_packer.sv
// Directed bench for fsm_bit_packer: words are checked through a scoreboard
// queue, detector outputs against the expected match positions.
module tb_fsm_bit_packer;

  localparam int WIDTH = 8;
  localparam int CNT_W = 2;
`ifdef PATTERN_DET_EN
  localparam bit DET_EN = 1'b1;
`else
  localparam bit DET_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             bit_in;
  logic             bit_vld;
  logic             frame_clr;
  logic             data_rdy;
  logic [WIDTH-1:0] data_out;
  logic             data_vld;
  logic             overflow;
  logic             det;
  logic [CNT_W-1:0] det_cnt;

  int total  = 0;
  int passed = 0;
  int fails  = 0;
  logic [WIDTH-1:0] exp_q[$];

  fsm_bit_packer #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bit_in    (bit_in),
    .bit_vld   (bit_vld),
    .frame_clr (frame_clr),
    .data_out  (data_out),
    .data_vld  (data_vld),
    .data_rdy  (data_rdy),
    .overflow  (overflow),
    .det       (det),
    .det_cnt   (det_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bit_in  = b;
    bit_vld = 1'b1;
    step();
    bit_vld = 1'b0;
    bit_in  = 1'b0;
  endtask

  task automatic send_word(input logic [WIDTH-1:0] w, input bit push);
    for (int i = WIDTH - 1; i >= 0; i--) send_bit(w[i]);
    if (push) exp_q.push_back(w);
  endtask

  task automatic chk_word(input string tag);
    logic [WIDTH-1:0] exp_w;
    if (exp_q.size() == 0) begin
      total++;
      fails++;
      $error("FAIL %s: observed word %0h with empty scoreboard", tag, data_out);
    end else begin
      exp_w = exp_q.pop_front();
      chk({tag, "_vld"}, data_vld, 1);
      chk({tag, "_data"}, data_out, exp_w);
    end
  endtask

  task automatic chk_det(input string tag, input bit match, input int cnt);
    chk({tag, "_det"}, det, DET_EN ? match : 1'b0);
    chk({tag, "_cnt"}, det_cnt, DET_EN ? cnt : 0);
  endtask

  logic ov_bits [7] = '{1, 0, 1, 1, 0, 1, 1};
  logic sat_bits[8] = '{1, 1, 0, 1, 1, 0, 1, 1};

  initial begin
    rst = 1'b0; bit_in = 1'b0; bit_vld = 1'b0; frame_clr = 1'b0; data_rdy = 1'b0;
    step();
    step();
    chk("rst_dout", data_out, 0);
    chk("rst_vld", data_vld, 0);
    chk("rst_ovf", overflow, 0);
    chk_det("rst", 1'b0, 0);
    rst = 1'b1;

    // reset in the middle of a word
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_vld", data_vld, 0);
    chk("async_rst_dout", data_out, 0);
    chk_det("async_rst", 1'b0, 0);
    step();
    rst = 1'b1;
    data_rdy = 1'b1;
    send_word(8'hAA, 1'b1);
    chk_word("after_rst_AA");
    step();
    chk("AA_consumed", data_vld, 0);

    // back-to-back words with the consumer always ready
    send_word(8'h3C, 1'b1);
    chk_word("b2b_3C");
    send_word(8'hC3, 1'b1);
    chk_word("b2b_C3");
    chk("b2b_ovf", overflow, 0);
    step();

    // overlapping detection with gaps between qualified bits
    frame_clr = 1'b1;
    step();
    frame_clr = 1'b0;
    for (int i = 0; i < 7; i++) begin
      send_bit(ov_bits[i]);
      chk("ov_det_bit", det, (DET_EN && (i == 3 || i == 6)) ? 1 : 0);
      step();
      chk("ov_det_gap", det, 0);
    end
    chk("ov_cnt", det_cnt, DET_EN ? 2 : 0);
    send_bit(1'b0);
    exp_q.push_back(8'hB6);
    chk_word("ov_word_B6");

    // three more matches saturate the 2-bit counter
    for (int i = 0; i < 8; i++) send_bit(sat_bits[i]);
    exp_q.push_back(8'hDB);
    chk_det("sat", 1'b1, 3);
    chk_word("sat_word_DB");
    step();

    // backpressure: second word is dropped
    data_rdy = 1'b0;
    send_word(8'h5A, 1'b1);
    chk("bp_first_vld", data_vld, 1);
    chk("bp_first_data", data_out, 8'h5A);
    send_word(8'hF0, 1'b0);
    chk("bp_hold_vld", data_vld, 1);
    chk("bp_hold_data", data_out, 8'h5A);
    chk("bp_ovf", overflow, 1);
    data_rdy = 1'b1;
    chk_word("bp_consume_5A");
    step();
    chk("bp_after_vld", data_vld, 0);
    chk("bp_ovf_sticky", overflow, 1);

    // frame_clr wins over a simultaneous qualified bit
    for (int i = 0; i < 3; i++) send_bit(1'b0);
    frame_clr = 1'b1;
    bit_in    = 1'b1;
    bit_vld   = 1'b1;
    step();
    frame_clr = 1'b0;
    bit_vld   = 1'b0;
    bit_in    = 1'b0;
    chk("clr_ovf", overflow, 0);
    chk("clr_vld", data_vld, 0);
    chk("clr_dout_held", data_out, 8'h5A);
    chk_det("clr", 1'b0, 0);
    send_word(8'h69, 1'b1);
    chk_word("clr_restart_69");
    step();
    chk("final_vld", data_vld, 0);
    chk("final_sb_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
